// File: rtl/nibbler_pkg.sv
// Shared Nibbler definitions: opcode encodings, sequencer state type and the
// default program counter width.
package nibbler_pkg;

    localparam int NIB_PC_W = 12;

    localparam logic [3:0] OP_JC  = 4'h0;
    localparam logic [3:0] OP_JNC = 4'h1;
    localparam logic [3:0] OP_JZ  = 4'h2;
    localparam logic [3:0] OP_JNZ = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/nibbler_jump_cond.sv
// Jump condition decode: decides from the opcode nibble and the ALU flags
// whether a jump instruction loads its target.
module nibbler_jump_cond
    import nibbler_pkg::*;
(
    input  logic [3:0] instruction,
    input  logic       carry_flag,
    input  logic       zero_flag,
    output logic       take_jump
);

    always_comb begin
        take_jump = 1'b0;
        case (instruction)
            OP_JC:   take_jump = carry_flag;
            OP_JNC:  take_jump = ~carry_flag;
            OP_JZ:   take_jump = zero_flag;
            OP_JNZ:  take_jump = ~zero_flag;
            OP_JMP:  take_jump = 1'b1;
            default: take_jump = 1'b0;
        endcase
    end

endmodule

// File: rtl/nibbler_sequencer.sv
// Nibbler front-end sequencer: owns the program counter and the two-phase
// fetch/execute cycle, with free-run, single-step and halt control.
module nibbler_sequencer
    import nibbler_pkg::*;
#(
    parameter int              PC_W     = NIB_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run_en,
    input  logic            step,
    input  logic [7:0]      programByte,
    input  logic [3:0]      instruction,
    input  logic [3:0]      operand,
    input  logic            carry_flag,
    input  logic            zero_flag,
    output logic [PC_W-1:0] pc,
    output logic            phase,
    output logic            jump_taken,
    output logic            instr_done,
    output logic            halted
);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            jump_nxt;
    logic            done_nxt;
    logic            halted_nxt;
    logic            take_jump;

    nibbler_jump_cond u_jump_cond (
        .instruction (instruction),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .take_jump   (take_jump)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            phase      <= 1'b0;
            jump_taken <= 1'b0;
            instr_done <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            phase      <= (state_nxt == S_EXEC);
            jump_taken <= jump_nxt;
            instr_done <= done_nxt;
            halted     <= halted_nxt;
        end
    end

    // The pulse outputs are registered so they line up with the pc value they describe.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        jump_nxt   = 1'b0;
        done_nxt   = 1'b0;
        halted_nxt = halted;
        case (state)
            S_IDLE: begin
                if (run_en || step) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                pc_nxt    = pc + PC_W'(1);
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                done_nxt = 1'b1;
                if (take_jump) begin
                    pc_nxt   = PC_W'({operand, programByte});
                    jump_nxt = 1'b1;
                end else begin
                    pc_nxt = pc + PC_W'(1);
                end
                if (instruction == OP_HLT) begin
                    state_nxt  = S_HALT;
                    halted_nxt = 1'b1;
                end else if (run_en) begin
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Bench for nibbler_sequencer: ROM + Fetch latch model around the DUT, an
// instruction-level reference model feeding a scoreboard checked on instr_done.
module tb_nibbler_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run_en = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  programByte;
    logic [3:0]  instruction = 4'h0;
    logic [3:0]  operand = 4'h0;
    logic        carry_flag = 1'b0;
    logic        zero_flag = 1'b0;
    logic [11:0] pc;
    logic        phase;
    logic        jump_taken;
    logic        instr_done;
    logic        halted;

    logic [7:0]  rom [0:4095];

    typedef struct {
        logic [11:0] pc;
        bit          jt;
        bit          hl;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    logic [11:0] mpc = 12'h000;
    bit          mhalt = 1'b0;

    nibbler_sequencer #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .clk         (clk),
        .reset       (reset),
        .run_en      (run_en),
        .step        (step),
        .programByte (programByte),
        .instruction (instruction),
        .operand     (operand),
        .carry_flag  (carry_flag),
        .zero_flag   (zero_flag),
        .pc          (pc),
        .phase       (phase),
        .jump_taken  (jump_taken),
        .instr_done  (instr_done),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    assign programByte = rom[pc];

    // Fetch stage stand-in: captures the opcode byte on every phase-0 edge.
    always @(posedge clk) begin
        if (!phase) begin
            instruction <= programByte[7:4];
            operand     <= programByte[3:0];
        end
    end

    // ISA-level reference: one whole instruction per call.
    function automatic void model_step(input logic [11:0] p, input bit c, input bit z,
                                       output logic [11:0] np, output bit tk, output bit hl);
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [11:0] p1;
        p1 = p + 12'd1;
        b0 = rom[p];
        b1 = rom[p1];
        case (b0[7:4])
            4'h0:    tk = c;
            4'h1:    tk = !c;
            4'h2:    tk = z;
            4'h3:    tk = !z;
            4'h4:    tk = 1'b1;
            default: tk = 1'b0;
        endcase
        hl = (b0[7:4] == 4'hF);
        np = tk ? {b0[3:0], b1} : p + 12'd2;
    endfunction

    function automatic void push_expected(input bit c, input bit z);
        logic [11:0] np;
        bit          tk;
        bit          hl;
        exp_t        e;
        if (!mhalt) begin
            model_step(mpc, c, z, np, tk, hl);
            e.pc = np;
            e.jt = tk;
            e.hl = hl;
            q.push_back(e);
            mpc   = np;
            mhalt = hl;
        end
    endfunction

    always @(negedge clk) begin
        if (reset && instr_done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_instr_done pc=%h jt=%b halted=%b", pc, jump_taken, halted);
            end else begin
                mon_e = q.pop_front();
                if (pc !== mon_e.pc || jump_taken !== mon_e.jt || halted !== mon_e.hl) begin
                    errors++;
                    $display("FAIL instr got pc=%h jt=%b halted=%b want pc=%h jt=%b halted=%b",
                             pc, jump_taken, halted, mon_e.pc, mon_e.jt, mon_e.hl);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h50;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_pc", pc, 12'h000);
        chk("rst_phase", phase, 0);
        chk("rst_halted", halted, 0);
        chk("rst_pulses", {jump_taken, instr_done}, 0);
        run_en = 1'b0;
        step   = 1'b0;
        q.delete();
        mpc   = 12'h000;
        mhalt = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_n(input int n, input bit frc, input bit fc, input bit fz);
        bit ec[$];
        bit ez[$];
        for (int i = 0; i < n; i++) begin
            bit c;
            bit z;
            c = frc ? fc : 1'($urandom);
            z = frc ? fz : 1'($urandom);
            ec.push_back(c);
            ez.push_back(z);
            push_expected(c, z);
        end
        @(negedge clk);
        run_en = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            carry_flag = 1'($urandom);
            zero_flag  = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            carry_flag = ec[k];
            zero_flag  = ez[k];
            if (k == n - 1) run_en = 1'b0;
        end
        @(posedge clk);
        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
    endtask

    task automatic step_one();
        carry_flag = 1'($urandom);
        zero_flag  = 1'($urandom);
        push_expected(carry_flag, zero_flag);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk("step_fetch_phase", phase, 0);
        @(negedge clk);
        chk("step_exec_phase", phase, 1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (4) @(negedge clk);
        chk("step_idle_pc", pc, mpc);
        chk("step_idle_phase", phase, 0);
        chk("step_queue_drained", q.size(), 0);
    endtask

    initial begin
        // Reset held with run_en=1, then free-run of no-ops.
        fill_nop();
        run_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_pc", pc, 12'h000);
            chk("hold_phase", phase, 0);
            chk("hold_halted", halted, 0);
        end
        for (int i = 0; i < 4; i++) push_expected(1'b0, 1'b0);
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("run_pc", pc, k - 1);
            chk("run_phase", phase, (k % 2 == 0));
            chk("run_done", instr_done, (k >= 3 && (k % 2 == 1)));
            if (k == 8) run_en = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("run_queue_drained", q.size(), 0);

        // Unconditional jump.
        rom[0] = 8'h45;
        rom[1] = 8'hA7;
        do_reset();
        run_n(1, 1'b1, 1'b0, 1'b0);
        chk("jmp_pc", pc, 12'h5A7);
        chk("jmp_pulse_ended", jump_taken, 0);

        // Conditional jumps with both flag polarities.
        for (int op = 0; op < 4; op++) begin
            for (int v = 0; v < 2; v++) begin
                fill_nop();
                rom[0] = {4'(op), 4'h3};
                rom[1] = 8'h10;
                do_reset();
                run_n(1, 1'b1, 1'(v), 1'(v));
                chk("cond_pc", pc, (op[0] ^ (v == 1)) ? 12'h310 : 12'h002);
            end
        end

        // Single step; a second step during EXEC must be ignored.
        fill_nop();
        do_reset();
        step_one();
        step_one();
        chk("step_pc", pc, 12'h004);

        // HLT at 00A, then run/step toggling while halted.
        rom[12'h00A] = 8'hF0;
        do_reset();
        run_n(8, 1'b0, 1'b0, 1'b0);
        chk("hlt_halted", halted, 1);
        chk("hlt_pc", pc, 12'h00C);
        repeat (10) begin
            @(negedge clk);
            run_en = 1'($urandom);
            step   = 1'($urandom);
            @(negedge clk);
            chk("frozen", {halted, phase, pc}, {1'b1, 1'b0, 12'h00C});
        end
        run_en = 1'b0;
        step   = 1'b0;
        do_reset();

        // pc wrap: jump to FFE, execute a no-op there.
        fill_nop();
        rom[0] = 8'h4F;
        rom[1] = 8'hFE;
        do_reset();
        run_n(2, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc", pc, 12'h000);

        // Asynchronous reset in the middle of a JMP's EXEC cycle.
        rom[0] = 8'h45;
        rom[1] = 8'hA7;
        do_reset();
        @(negedge clk);
        run_en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_pc", pc, 12'h000);
        chk("async_phase", phase, 0);
        run_en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("async_hold", {jump_taken, pc}, 13'h0000);
        end
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        mpc   = 12'h000;
        mhalt = 1'b0;

        // Random programs with random flags, free-run mixed with steps.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4096; i++) begin
                logic [3:0] opc;
                opc = 4'($urandom_range(0, 15));
                if (opc == 4'hF && $urandom_range(0, 3) != 0) opc = 4'h5;
                rom[i] = {opc, 4'($urandom)};
            end
            do_reset();
            run_n($urandom_range(4, 20), 1'b0, 1'b0, 1'b0);
            if (!mhalt) step_one();
            if (!mhalt) run_n($urandom_range(2, 10), 1'b0, 1'b0, 1'b0);
            chk("rand_halted", halted, mhalt);
            chk("rand_pc", pc, mpc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
